// File: rtl/vj_scale_ctrl_pkg.sv
// Shared definitions for the Viola-Jones scale-pyramid scheduler.
// Contents:
//   - window/picture geometry constants (W_SIZE, W_PW, W_PH)
//   - step schedule defaults (STEP_MIN, STEP_INC, STEP_MAX)
//   - controller state encoding
//   - half_mul(): (v * step) >> 1, the scaled-to-native coordinate map
package vj_scale_ctrl_pkg;

  localparam int W_SIZE   = 24;  // detection window edge, pixels
  localparam int W_PW     = 9;   // MSB index of picture width fields
  localparam int W_PH     = 9;   // MSB index of picture height fields
  localparam int STEP_MIN = 2;   // half-pixel units, 2 = 1:1
  localparam int STEP_INC = 1;
  localparam int STEP_MAX = 31;
  localparam int STEP_W   = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DIV   = 3'd1,
    ST_CHECK = 3'd2,
    ST_GO    = 3'd3,
    ST_RUN   = 3'd4,
    ST_NEXT  = 3'd5,
    ST_DONE  = 3'd6
  } vj_state_e;

  // step is in half-pixel units, so a scaled coordinate maps back to the
  // native grid as (v * step) / 2.
  function automatic logic [15:0] half_mul(input logic [15:0] v,
                                           input logic [STEP_W-1:0] s);
    logic [20:0] p;
    p = 21'(v) * 21'(s);
    return p[16:1];
  endfunction

endpackage

// File: rtl/vj_scale_ctrl_if.sv
// Link between the scale scheduler and the window fetcher / cascade pair.
// Handshake:
//   vj_fetch_go is a one-cycle launch pulse. vj_pic_width, vj_pic_height
//   and vj_step are valid when it is high and stay stable until the next
//   launch. vj_frame_ready is a one-cycle completion pulse from the fetcher
//   and is only taken while the scheduler waits on a pass. face_detected
//   is a one-cycle hit qualifier for vj_col/vj_row (scaled domain).
// Modports: master = scheduler, slave = fetcher/cascade.
interface vj_scale_ctrl_if
  import vj_scale_ctrl_pkg::*;
  ;
  logic              vj_fetch_go;
  logic [W_PW:0]     vj_pic_width;
  logic [W_PH:0]     vj_pic_height;
  logic [STEP_W-1:0] vj_step;
  logic              vj_frame_ready;
  logic              face_detected;
  logic [W_PW:0]     vj_col;
  logic [W_PH:0]     vj_row;

  modport master (
    output vj_fetch_go, vj_pic_width, vj_pic_height, vj_step,
    input  vj_frame_ready, face_detected, vj_col, vj_row
  );

  modport slave (
    input  vj_fetch_go, vj_pic_width, vj_pic_height, vj_step,
    output vj_frame_ready, face_detected, vj_col, vj_row
  );

endinterface

// File: rtl/vj_scale_ctrl_udiv.sv
// vj_udiv: restoring unsigned divider, one quotient bit per cycle.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start_i    load num_i/den_i; the first quotient bit is produced in the
//              same cycle, so done_o pulses N cycles after start_i
//   num_i      N-bit numerator
//   den_i      D-bit divisor, never zero
//   done_o     one-cycle completion pulse
//   quo_o      quotient, valid from done_o until the next start_i
module vj_udiv #(
  parameter int N = 11,
  parameter int D = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [N-1:0] num_i,
  input  logic [D-1:0] den_i,
  output logic         done_o,
  output logic [N-1:0] quo_o
);

  localparam int CW = $clog2(N + 1);

  logic [D-1:0]  rem_q, rem_d;
  logic [N-1:0]  quo_q, quo_d;   // numerator bits shift out, quotient in
  logic [D-1:0]  den_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;

  logic [D-1:0]  src_rem;
  logic [N-1:0]  src_quo;
  logic [D-1:0]  src_den;
  logic [D:0]    shifted;

  // One restoring iteration; on start it operates directly on the inputs.
  always_comb begin
    src_rem = start_i ? '0    : rem_q;
    src_quo = start_i ? num_i : quo_q;
    src_den = start_i ? den_i : den_q;
    shifted = {src_rem, src_quo[N-1]};
    rem_d   = shifted[D-1:0];
    quo_d   = {src_quo[N-2:0], 1'b0};
    // remainder stays below the divisor, so the top bit is zero whenever
    // no subtraction happens
    if (shifted >= {1'b0, src_den}) begin
      rem_d = D'(shifted - {1'b0, src_den});
      quo_d = {src_quo[N-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        rem_q  <= rem_d;
        quo_q  <= quo_d;
        den_q  <= den_i;
        cnt_q  <= CW'(N - 1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o = done_q;
  assign quo_o  = quo_q;

endmodule

// File: rtl/vj_scale_ctrl.sv
// vj_scale_ctrl: scale-pyramid scheduler for the Viola-Jones window fetcher.
// For each step from STEP_MIN upward it divides the native picture size by
// step/2, launches one fetch/cascade pass while the scaled picture still
// holds a full window, and maps every hit back to native coordinates.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   frame_go        start-of-frame pulse (taken only when idle)
//   abort           abandon the current frame (ignored when idle)
//   pic_width/height native picture size
//   vj              fetcher link (master side)
//   det_valid       one-cycle detection strobe; det_x/det_y/det_size hold
//   busy            frame in progress
//   scale_idx       0-based index of the most recently launched pass
//   frame_done      one-cycle end-of-frame pulse
//   frame_aborted   one-cycle abort acknowledge
//   face_count      hits this frame, saturating
//   state_dbg       current controller state
module vj_scale_ctrl
  import vj_scale_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_go,
  input  logic              abort,
  input  logic [W_PW:0]     pic_width,
  input  logic [W_PH:0]     pic_height,
  vj_scale_ctrl_if.master   vj,
  output logic              det_valid,
  output logic [W_PW:0]     det_x,
  output logic [W_PH:0]     det_y,
  output logic [9:0]        det_size,
  output logic              busy,
  output logic [STEP_W-1:0] scale_idx,
  output logic              frame_done,
  output logic              frame_aborted,
  output logic [15:0]       face_count,
  output vj_state_e         state_dbg
);

  vj_state_e         state_q, state_d;
  logic [W_PW:0]     pic_w_q;
  logic [W_PH:0]     pic_h_q;
  logic [STEP_W-1:0] step_q;
  logic [STEP_W-1:0] idx_q;        // pass counter, advanced in NEXT
  logic              div_first_q;  // first cycle of DIV
  logic              got_w_q, got_h_q;
  logic              go_q;
  logic [W_PW:0]     vj_w_q;
  logic [W_PH:0]     vj_h_q;
  logic [STEP_W-1:0] vj_step_q;
  logic [STEP_W-1:0] scale_idx_q;
  logic              det_valid_q;
  logic [W_PW:0]     det_x_q;
  logic [W_PH:0]     det_y_q;
  logic [9:0]        det_size_q;
  logic [15:0]       face_count_q;
  logic              aborted_q;

  logic              w_done, h_done;
  logic [W_PW+1:0]   qw;
  logic [W_PH+1:0]   qh;
  logic [STEP_W:0]   step_nxt;
  logic              hit;

  // floor(2*pic / step): the numerator is the picture size doubled because
  // step counts half pixels.
  vj_udiv #(.N(W_PW + 2), .D(STEP_W)) u_div_w (
    .clk     (clk),
    .rst     (rst),
    .start_i (div_first_q),
    .num_i   ({pic_w_q, 1'b0}),
    .den_i   (step_q),
    .done_o  (w_done),
    .quo_o   (qw)
  );

  vj_udiv #(.N(W_PH + 2), .D(STEP_W)) u_div_h (
    .clk     (clk),
    .rst     (rst),
    .start_i (div_first_q),
    .num_i   ({pic_h_q, 1'b0}),
    .den_i   (step_q),
    .done_o  (h_done),
    .quo_o   (qh)
  );

  assign step_nxt = {1'b0, step_q} + (STEP_W + 1)'(STEP_INC);
  assign hit      = (state_q == ST_RUN) && vj.face_detected;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (frame_go) state_d = ST_DIV;
      ST_DIV:   if ((got_w_q || w_done) && (got_h_q || h_done)) state_d = ST_CHECK;
      ST_CHECK: begin
        if (qw >= (W_PW + 2)'(W_SIZE) && qh >= (W_PH + 2)'(W_SIZE) &&
            {1'b0, step_q} <= (STEP_W + 1)'(STEP_MAX))
          state_d = ST_GO;
        else
          state_d = ST_DONE;
      end
      ST_GO:    state_d = ST_RUN;
      ST_RUN:   if (vj.vj_frame_ready) state_d = ST_NEXT;
      // a step that no longer fits the 5-bit field ends the frame
      ST_NEXT:  state_d = step_nxt[STEP_W] ? ST_DONE : ST_DIV;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort && state_q != ST_IDLE) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pic_w_q      <= '0;
      pic_h_q      <= '0;
      step_q       <= STEP_W'(STEP_MIN);
      idx_q        <= '0;
      div_first_q  <= 1'b0;
      got_w_q      <= 1'b0;
      got_h_q      <= 1'b0;
      go_q         <= 1'b0;
      vj_w_q       <= '0;
      vj_h_q       <= '0;
      vj_step_q    <= STEP_W'(STEP_MIN);
      scale_idx_q  <= '0;
      det_valid_q  <= 1'b0;
      det_x_q      <= '0;
      det_y_q      <= '0;
      det_size_q   <= '0;
      face_count_q <= '0;
      aborted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_first_q <= (state_d == ST_DIV) && (state_q != ST_DIV);
      go_q        <= (state_q == ST_GO) && (state_d == ST_RUN);
      aborted_q   <= abort && (state_q != ST_IDLE);
      det_valid_q <= 1'b0;

      // done flags from a previous pass are cleared before DIV re-enters
      if (state_q != ST_DIV) begin
        got_w_q <= 1'b0;
        got_h_q <= 1'b0;
      end else begin
        if (w_done) got_w_q <= 1'b1;
        if (h_done) got_h_q <= 1'b1;
      end

      if (state_q == ST_IDLE && frame_go) begin
        pic_w_q      <= pic_width;
        pic_h_q      <= pic_height;
        step_q       <= STEP_W'(STEP_MIN);
        idx_q        <= '0;
        scale_idx_q  <= '0;
        face_count_q <= '0;
      end

      if (state_q == ST_GO && state_d == ST_RUN) begin
        vj_w_q      <= qw[W_PW:0];
        vj_h_q      <= qh[W_PH:0];
        vj_step_q   <= step_q;
        scale_idx_q <= idx_q;
      end

      if (state_q == ST_NEXT) begin
        step_q <= step_nxt[STEP_W-1:0];
        idx_q  <= idx_q + STEP_W'(1);
      end

      if (hit) begin
        det_valid_q <= 1'b1;
        det_x_q     <= (W_PW + 1)'(half_mul(16'(vj.vj_col), vj_step_q));
        det_y_q     <= (W_PH + 1)'(half_mul(16'(vj.vj_row), vj_step_q));
        det_size_q  <= 10'(half_mul(16'(W_SIZE), vj_step_q));
        if (face_count_q != 16'hFFFF) face_count_q <= face_count_q + 16'd1;
      end
    end
  end

  assign vj.vj_fetch_go   = go_q;
  assign vj.vj_pic_width  = vj_w_q;
  assign vj.vj_pic_height = vj_h_q;
  assign vj.vj_step       = vj_step_q;

  assign det_valid     = det_valid_q;
  assign det_x         = det_x_q;
  assign det_y         = det_y_q;
  assign det_size      = det_size_q;
  assign busy          = (state_q != ST_IDLE);
  assign scale_idx     = scale_idx_q;
  assign frame_done    = (state_q == ST_DONE);
  assign frame_aborted = aborted_q;
  assign face_count    = face_count_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_vj_scale_ctrl.sv
module tb_vj_scale_ctrl;
  import vj_scale_ctrl_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_go;
  logic          abort;
  logic [W_PW:0] pic_width;
  logic [W_PH:0] pic_height;
  logic          det_valid;
  logic [W_PW:0] det_x;
  logic [W_PH:0] det_y;
  logic [9:0]    det_size;
  logic          busy;
  logic [4:0]    scale_idx;
  logic          frame_done;
  logic          frame_aborted;
  logic [15:0]   face_count;
  vj_state_e     state_dbg;

  int checks = 0;
  int errors = 0;

  int go_w[32];
  int go_h[32];
  int go_s[32];
  int n_go, n_done, ncyc, last_idx;
  bit fin, ok;
  int cnt_a, cnt_b;

  always #5 clk = ~clk;

  vj_scale_ctrl_if vif();

  vj_scale_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .frame_go      (frame_go),
    .abort         (abort),
    .pic_width     (pic_width),
    .pic_height    (pic_height),
    .vj            (vif.master),
    .det_valid     (det_valid),
    .det_x         (det_x),
    .det_y         (det_y),
    .det_size      (det_size),
    .busy          (busy),
    .scale_idx     (scale_idx),
    .frame_done    (frame_done),
    .frame_aborted (frame_aborted),
    .face_count    (face_count),
    .state_dbg     (state_dbg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Launch a frame and act as the fetcher: vj_frame_ready 50 cycles after
  // every go. Stops at frame_done or after max_cycles.
  task automatic run_frame(input int w, input int h, input int max_cycles);
    int cd;
    cd = 0;
    n_go = 0; n_done = 0; ncyc = 0; fin = 0; last_idx = -1;
    pic_width = 10'(w);
    pic_height = 10'(h);
    frame_go = 1'b1;
    while (!fin && ncyc < max_cycles) begin
      tick();
      ncyc++;
      frame_go = 1'b0;
      vif.vj_frame_ready = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) vif.vj_frame_ready = 1'b1;
      end
      if (vif.vj_fetch_go) begin
        if (n_go < 32) begin
          go_w[n_go] = int'(vif.vj_pic_width);
          go_h[n_go] = int'(vif.vj_pic_height);
          go_s[n_go] = int'(vif.vj_step);
        end
        n_go++;
        cd = 50;
      end
      if (frame_done) begin
        n_done++;
        fin = 1;
        last_idx = int'(scale_idx);
      end
    end
    vif.vj_frame_ready = 1'b0;
  endtask

  task automatic wait_go(input int max_cycles, output bit got);
    int n;
    n = 0;
    got = 0;
    while (!got && n < max_cycles) begin
      tick();
      n++;
      if (vif.vj_fetch_go) got = 1;
    end
  endtask

  task automatic pulse_ready();
    vif.vj_frame_ready = 1'b1;
    tick();
    vif.vj_frame_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    frame_go = 1'b0;
    abort = 1'b0;
    pic_width = '0;
    pic_height = '0;
    vif.vj_frame_ready = 1'b0;
    vif.face_detected = 1'b0;
    vif.vj_col = '0;
    vif.vj_row = '0;

    // reset state
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_busy", int'(busy), 0);
    check("rst_step", int'(vif.vj_step), 2);
    check("rst_go", int'(vif.vj_fetch_go), 0);
    check("rst_width", int'(vif.vj_pic_width), 0);
    check("rst_det_valid", int'(det_valid), 0);
    check("rst_face_count", int'(face_count), 0);
    check("rst_done", int'(frame_done), 0);

    // 320x240 full pyramid: steps 2..20
    run_frame(320, 240, 3000);
    check("f320_finished", int'(fin), 1);
    check("f320_passes", n_go, 19);
    check("f320_s0", go_s[0], 2);
    check("f320_w0", go_w[0], 320);
    check("f320_h0", go_h[0], 240);
    check("f320_s1", go_s[1], 3);
    check("f320_w1", go_w[1], 213);
    check("f320_h1", go_h[1], 160);
    check("f320_s18", go_s[18], 20);
    check("f320_w18", go_w[18], 32);
    check("f320_h18", go_h[18], 24);
    check("f320_idx", last_idx, 18);
    check("f320_faces", int'(face_count), 0);
    tick();
    check("f320_busy_after", int'(busy), 0);
    cnt_a = 0;
    for (int i = 0; i < 5; i++) begin
      if (frame_done) cnt_a++;
      tick();
    end
    check("f320_done_once", n_done + cnt_a, 1);

    // 24x24: exactly one pass
    run_frame(24, 24, 500);
    check("f24_finished", int'(fin), 1);
    check("f24_passes", n_go, 1);
    check("f24_w0", go_w[0], 24);
    check("f24_h0", go_h[0], 24);
    check("f24_s0", go_s[0], 2);
    check("f24_faces", int'(face_count), 0);
    tick();

    // 20x100: no pass, quick frame_done
    run_frame(20, 100, 100);
    check("f20_finished", int'(fin), 1);
    check("f20_passes", n_go, 0);
    check("f20_latency_ok", int'(ncyc <= W_PW + 6), 1);
    tick();

    // detection path and abort on a 320x240 frame
    pic_width = 10'd320;
    pic_height = 10'd240;
    frame_go = 1'b1;
    tick();
    frame_go = 1'b0;
    wait_go(100, ok);
    check("d_go1", int'(ok), 1);
    pulse_ready();            // RUN -> NEXT
    tick();                   // now in DIV
    vif.face_detected = 1'b1;
    vif.vj_col = 10'd7;
    vif.vj_row = 10'd3;
    tick();
    vif.face_detected = 1'b0;
    check("d_div_hit_valid", int'(det_valid), 0);
    check("d_div_hit_count", int'(face_count), 0);
    wait_go(100, ok);
    check("d_go2", int'(ok), 1);
    check("d_step3", int'(vif.vj_step), 3);
    frame_go = 1'b1;          // mid-frame frame_go must not restart
    tick();
    frame_go = 1'b0;
    pulse_ready();
    wait_go(100, ok);
    check("d_go3", int'(ok), 1);
    check("d_step4", int'(vif.vj_step), 4);
    check("d_idx2", int'(scale_idx), 2);
    check("d_w4", int'(vif.vj_pic_width), 160);
    check("d_h4", int'(vif.vj_pic_height), 120);
    vif.face_detected = 1'b1;
    vif.vj_col = 10'd10;
    vif.vj_row = 10'd5;
    tick();
    vif.face_detected = 1'b0;
    check("d_valid", int'(det_valid), 1);
    check("d_x", int'(det_x), 20);
    check("d_y", int'(det_y), 10);
    check("d_size", int'(det_size), 48);
    check("d_count", int'(face_count), 1);
    tick();
    check("d_valid_pulse", int'(det_valid), 0);
    check("d_x_hold", int'(det_x), 20);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("a_aborted", int'(frame_aborted), 1);
    check("a_busy", int'(busy), 0);
    check("a_no_done", int'(frame_done), 0);
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (frame_done) cnt_a++;
      if (vif.vj_fetch_go || frame_aborted) cnt_b++;
    end
    check("a_quiet_done", cnt_a, 0);
    check("a_quiet_go", cnt_b, 0);
    abort = 1'b1;             // abort while idle is ignored
    tick();
    abort = 1'b0;
    check("a_idle_abort", int'(frame_aborted), 0);

    // restart with frame_go and abort together in IDLE
    frame_go = 1'b1;
    abort = 1'b1;
    tick();
    frame_go = 1'b0;
    abort = 1'b0;
    check("r_busy", int'(busy), 1);
    check("r_count", int'(face_count), 0);
    check("r_no_abort", int'(frame_aborted), 0);
    wait_go(100, ok);
    check("r_go", int'(ok), 1);
    check("r_step", int'(vif.vj_step), 2);
    check("r_w", int'(vif.vj_pic_width), 320);
    check("r_idx", int'(scale_idx), 0);

    // reset mid-DIV
    pulse_ready();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("m_busy", int'(busy), 0);
    check("m_step", int'(vif.vj_step), 2);
    check("m_w", int'(vif.vj_pic_width), 0);
    check("m_h", int'(vif.vj_pic_height), 0);
    check("m_det_x", int'(det_x), 0);
    check("m_det_size", int'(det_size), 0);
    check("m_count", int'(face_count), 0);
    check("m_state", int'(state_dbg), int'(ST_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vj_scale_ctrl.md
Name: vj_scale_ctrl

Overview:
- Scale-pyramid scheduler for the Viola-Jones window fetcher. For one frame, it steps the sub-sampling factor `step` from STEP_MIN upward.
- For each scale it computes the scaled picture size, launches one full fetch/cascade pass (`vj_fetch_go`) and waits for `vj_frame_ready`.
- It maps each `face_detected` back to native-resolution coordinates.
- It sits between the frame-level top controller and the fetcher/cascade pair.

Parameters:
- W_SIZE, 24, detection window edge in pixels.
- W_PW, 9, MSB index of picture width fields.
- W_PH, 9, MSB index of picture height fields.
- STEP_MIN, 2, first step; step is in half-pixel units, so 2 = 1:1.
- STEP_INC, 1, step increment per scale.
- STEP_MAX, 31, last legal step (5-bit field).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- frame_go  in  1  start-of-frame pulse
- abort  in  1  abandon current frame
- pic_width  in  W_PW+1  native width
- pic_height  in  W_PH+1  native height
- vj_fetch_go  out  1  one-cycle launch of a scale pass
- vj_pic_width  out  W_PW+1  scaled width for current pass
- vj_pic_height  out  W_PH+1  scaled height for current pass
- vj_step  out  5  step for current pass
- vj_frame_ready  in  1  pass complete
- face_detected  in  1  window hit
- vj_col  in  W_PW+1  hit window column, scaled domain
- vj_row  in  W_PH+1  hit window row, scaled domain
- det_valid  out  1  detection record valid
- det_x  out  W_PW+1  native x of hit
- det_y  out  W_PH+1  native y of hit
- det_size  out  10  native window edge
- busy  out  1  frame in progress
- scale_idx  out  5  index of current scale, 0-based
- frame_done  out  1  one-cycle end-of-frame pulse
- frame_aborted  out  1  one-cycle abort acknowledge
- face_count  out  16  hits this frame, saturating

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous, active-high.
- Reset: state IDLE; all outputs 0; vj_step = STEP_MIN.
- States:
  - IDLE: on `frame_go`, latch pic_width/pic_height; step = STEP_MIN; scale_idx = 0; face_count = 0; busy = 1; go to DIV.
  - DIV: start both dividers on the state's first cycle. Width divider computes floor(2*pic_width/step); height divider computes the same for pic_height. Wait for both done pulses, then go to CHECK.
  - CHECK, 1 cycle: continue to GO only if qw >= W_SIZE, qh >= W_SIZE and step <= STEP_MAX. Otherwise go to DONE.
  - GO, 1 cycle: load vj_pic_width = qw, vj_pic_height = qh, vj_step = step; assert `vj_fetch_go` the following cycle. The three fields stay stable until the next GO. Go to RUN.
  - RUN: wait for `vj_frame_ready`, then go to NEXT.
  - NEXT, 1 cycle: step += STEP_INC; scale_idx += 1. Go to DIV. If step + STEP_INC would exceed 5 bits, go to DONE instead.
  - DONE, 1 cycle: frame_done = 1; busy = 0 next cycle; go to IDLE.
- Divider:
  - Restoring unsigned divider, 1 quotient bit per cycle.
  - Numerator width W_PW+2, so latency is W_PW+2 cycles from start to done.
  - Divisor is never 0, since STEP_MIN >= 1.
- Detection path:
  - `face_detected` is honoured only in RUN; it is ignored elsewhere.
  - One cycle later: det_valid = 1; det_x = (vj_col*vj_step)>>1; det_y = (vj_row*vj_step)>>1; det_size = (W_SIZE*vj_step)>>1.
  - The det_* fields hold until the next hit.
  - face_count increments per honoured hit and saturates at 0xFFFF.
  - A hit and `vj_frame_ready` in the same cycle are both honoured.
- Abort:
  - `abort` in any non-IDLE state goes to IDLE next cycle and pulses frame_aborted; busy = 0, no frame_done.
  - `vj_fetch_go` is not re-issued. Downstream draining is the top controller's responsibility.
  - `abort` in IDLE is ignored.
- Boundaries:
  - `frame_go` while busy: ignored.
  - `vj_frame_ready` outside RUN: ignored.
  - `frame_go` and `abort` in the same IDLE cycle: start the frame.
  - `rst` mid-frame: IDLE with all outputs reset next cycle.
  - A picture smaller than W_SIZE in either dimension gives zero passes: frame_done with face_count 0.

Decomposition:
- Shared package (global.v defines):
  - `W_SIZE`, `W_PW`, `W_PH`
  - state encoding for vj_scale_ctrl
  - STEP_MIN / STEP_INC / STEP_MAX defaults
- Sub-module vj_udiv: start/done restoring divider, instantiated twice (width, height).

Test Plan:
- 320x240, default parameters, `vj_frame_ready` returned 50 cycles after each go:
  - 19 `vj_fetch_go` pulses, steps 2..20.
  - First pass 320x240; step 3 pass 213x160; last pass 32x24.
  - frame_done once, scale_idx ends at 18.
- 24x24 -> exactly one pass (24x24, step 2); step 3 yields 16 -> frame_done; face_count 0.
- 20x100 -> no `vj_fetch_go`; frame_done within W_PW+6 cycles of frame_go.
- During step-4 pass, face_detected with vj_col=10, vj_row=5:
  - det_valid next cycle; det_x=20, det_y=10, det_size=48; face_count=1.
  - A face_detected pulse in DIV: no det_valid.
- abort during RUN of the 3rd scale -> frame_aborted 1 cycle later, busy 0, no frame_done. A new frame_go restarts at step 2 with face_count 0.
- frame_go repeated mid-frame: no effect. rst asserted mid-DIV: all outputs 0 next cycle, vj_step=2.
